// File: rtl/mem_copy_engine.sv
// Two-cycle-per-word memory copy engine. Each word is read into a hold
// register, then written out. Overlapping ranges where the destination sits
// above the source are copied backward so source words are read before they
// are overwritten.
module mem_copy_engine #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  output logic         Busy,
  output logic         Done,
  output logic [A-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWData,
  input  logic [W-1:0] MemRData
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e       r_state;
  logic [A-1:0] r_src;
  logic [A-1:0] r_dst;
  logic [A-1:0] r_cnt;
  logic [W-1:0] r_hold;
  logic         r_back;
  logic         r_busy;
  logic         r_done;

  logic [A-1:0] w_diff;
  logic         w_backward;
  logic [A-1:0] w_len_m1;

  // Direction decision on the unwrapped address difference.
  assign w_diff     = DstAddr - SrcAddr;
  assign w_backward = (DstAddr > SrcAddr) && (w_diff < Len);
  assign w_len_m1   = Len - A'(1);

  // Control FSM with datapath registers and registered Busy/Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_back  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (Start) begin
            if (Len != '0) begin
              r_back  <= w_backward;
              r_src   <= w_backward ? SrcAddr + w_len_m1 : SrcAddr;
              r_dst   <= w_backward ? DstAddr + w_len_m1 : DstAddr;
              r_cnt   <= Len;
              r_busy  <= 1'b1;
              r_state <= StRead;
            end else begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StRead: begin
          r_hold  <= MemRData;
          r_state <= StWrite;
        end
        StWrite: begin
          r_cnt <= r_cnt - A'(1);
          r_src <= r_back ? r_src - A'(1) : r_src + A'(1);
          r_dst <= r_back ? r_dst - A'(1) : r_dst + A'(1);
          if (r_cnt == A'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_state <= StRead;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Memory port decode; Reset blanks everything so an aborted copy cannot
  // write in the cycle reset is raised.
  always_comb begin
    Busy       = r_busy & ~Reset;
    Done       = r_done & ~Reset;
    MemAddr    = '0;
    MemWriteEn = 1'b0;
    MemWData   = '0;
    if (!Reset) begin
      if (r_state == StRead) begin
        MemAddr = r_src;
      end else if (r_state == StWrite) begin
        MemAddr    = r_dst;
        MemWriteEn = 1'b1;
        MemWData   = r_hold;
      end
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine with a word-by-word reference copy
// model, a bench-side data memory and per-cycle output checks.
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic       Busy, Done, MemWriteEn;
  logic [7:0] MemAddr, MemWData, MemRData;

  logic [7:0] dmem [256];
  logic [7:0] mmem [256];
  logic [7:0] src_seq [256];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];

  logic       poke_en = 1'b0;
  logic [7:0] poke_a = '0, poke_v = '0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int first_wa = 0;

  always #5 Clk = ~Clk;

  mem_copy_engine #(.W(8), .A(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .Busy       (Busy),
    .Done       (Done),
    .MemAddr    (MemAddr),
    .MemWriteEn (MemWriteEn),
    .MemWData   (MemWData),
    .MemRData   (MemRData)
  );

  // Data memory: combinational read, write at the clock edge.
  assign MemRData = dmem[MemAddr];
  always @(posedge Clk) begin
    if (poke_en) dmem[poke_a] <= poke_v;
    else if (MemWriteEn) dmem[MemAddr] <= MemWData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Every cycle: blanked outputs under reset, and each write against the model.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      chk("rst_busy", 32'(Busy), 0);
      chk("rst_done", 32'(Done), 0);
      chk("rst_addr", 32'(MemAddr), 0);
      chk("rst_we", 32'(MemWriteEn), 0);
      chk("rst_wdata", 32'(MemWData), 0);
    end
    if (MemWriteEn === 1'b1) begin
      if (wr_count == 0) first_wa = int'(MemAddr);
      wr_count++;
      if (exp_wa.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        chk("write_addr", 32'(MemAddr), 32'(exp_wa.pop_front()));
        chk("write_data", 32'(MemWData), 32'(exp_wd.pop_front()));
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge Clk);
    poke_en = 1'b1; poke_a = a; poke_v = v;
    mmem[a] = v;
    @(posedge Clk);
    #1 poke_en = 1'b0;
  endtask

  // Reference copy: word i moves src+-i to dst+-i, in order, on the model memory.
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input int nwords);
    logic       back;
    logic [7:0] diff, ps, pd;
    diff = d - s;
    back = (d > s) && (diff < l);
    ps = back ? s + l - 8'd1 : s;
    pd = back ? d + l - 8'd1 : d;
    for (int i = 0; i < nwords; i++) begin
      src_seq[i] = ps;
      exp_wa.push_back(pd);
      exp_wd.push_back(mmem[ps]);
      mmem[pd] = mmem[ps];
      ps = back ? ps - 8'd1 : ps + 8'd1;
      pd = back ? pd - 8'd1 : pd + 8'd1;
    end
  endtask

  task automatic mem_compare(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== mmem[i]) mism++;
    chk(name, mism, 0);
  endtask

  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input bit glitch);
    int n, total;
    n = int'(l);
    total = (n == 0) ? 1 : 2 * n + 1;
    exp_wa.delete(); exp_wd.delete();
    wr_count = 0;
    model_copy(s, d, l, n);
    @(negedge Clk);
    Start = 1'b1; SrcAddr = s; DstAddr = d; Len = l;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge Clk);
      chk("busy", 32'(Busy), 32'(k <= 2 * n));
      chk("done", 32'(Done), 32'(k == total));
      chk("we", 32'(MemWriteEn), 32'((k % 2 == 0) && (k <= 2 * n)));
      if ((k % 2 == 1) && (k < 2 * n)) begin
        chk("read_addr", 32'(MemAddr), 32'(src_seq[(k - 1) / 2]));
        chk("read_wdata", 32'(MemWData), 0);
      end
      if (k == total) chk("done_addr", 32'(MemAddr), 0);
      if (glitch && k == 2) begin
        Start = 1'b1;
        SrcAddr = 8'($urandom); DstAddr = 8'($urandom); Len = 8'($urandom_range(1, 255));
      end
      if (glitch && k == 3) Start = 1'b0;
    end
    @(negedge Clk);
    chk("idle_busy", 32'(Busy), 0);
    chk("idle_done", 32'(Done), 0);
    chk("queue_empty", exp_wa.size(), 0);
    chk("write_count", wr_count, n);
    mem_compare("mem_image");
  endtask

  // Reset during the second write of a 4-word copy, with Start held during reset.
  task automatic reset_test();
    logic [7:0] w0, keep1;
    w0 = mmem[60];
    keep1 = mmem[121];
    exp_wa.delete(); exp_wd.delete();
    wr_count = 0;
    model_copy(8'd60, 8'd120, 8'd4, 1);
    @(negedge Clk);
    Start = 1'b1; SrcAddr = 8'd60; DstAddr = 8'd120; Len = 8'd4;
    @(posedge Clk);
    #1 Start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      chk("rt_busy", 32'(Busy), 1);
    end
    @(posedge Clk);
    #1 Reset = 1'b1; Start = 1'b1; Len = 8'd5;
    @(negedge Clk);
    chk("rt_we_in_reset", 32'(MemWriteEn), 0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("rt_post_busy", 32'(Busy), 0);
      chk("rt_post_done", 32'(Done), 0);
      chk("rt_post_we", 32'(MemWriteEn), 0);
    end
    chk("rt_write_count", wr_count, 1);
    chk("rt_word0", 32'(dmem[120]), 32'(w0));
    chk("rt_word1_kept", 32'(dmem[121]), 32'(keep1));
    mem_compare("rt_mem_image");
  endtask

  initial begin
    logic [7:0] s, d, l;
    bit g;
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    repeat (3) @(negedge Clk);
    Start = 1'b1; Len = 8'd3;  // must be ignored under reset
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("after_rst_busy", 32'(Busy), 0);
    chk("after_rst_done", 32'(Done), 0);
    chk("after_rst_addr", 32'(MemAddr), 0);
    chk("after_rst_we", 32'(MemWriteEn), 0);

    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // Basic forward copy.
    poke(8'd10, 8'hAA); poke(8'd11, 8'hBB); poke(8'd12, 8'hCC); poke(8'd13, 8'hDD);
    do_copy(8'd10, 8'd40, 8'd4, 1'b0);
    chk("basic_40", 32'(dmem[40]), 32'hAA);
    chk("basic_41", 32'(dmem[41]), 32'hBB);
    chk("basic_42", 32'(dmem[42]), 32'hCC);
    chk("basic_43", 32'(dmem[43]), 32'hDD);
    chk("basic_writes", wr_count, 4);

    // Overlapping copy upward runs backward.
    for (int i = 0; i < 5; i++) poke(8'(20 + i), 8'(i + 1));
    do_copy(8'd20, 8'd22, 8'd5, 1'b0);
    chk("overlap_first_wa", first_wa, 26);
    for (int i = 0; i < 5; i++) chk("overlap_data", 32'(dmem[22 + i]), i + 1);

    // Source wraps through address 0.
    poke(8'd254, 8'd9); poke(8'd255, 8'd8); poke(8'd0, 8'd7); poke(8'd1, 8'd6);
    do_copy(8'd254, 8'd100, 8'd4, 1'b0);
    chk("wrap_100", 32'(dmem[100]), 9);
    chk("wrap_101", 32'(dmem[101]), 8);
    chk("wrap_102", 32'(dmem[102]), 7);
    chk("wrap_103", 32'(dmem[103]), 6);

    do_copy(8'd50, 8'd60, 8'd0, 1'b0);
    chk("len0_writes", wr_count, 0);

    reset_test();

    do_copy(8'd70, 8'd90, 8'd6, 1'b1);
    do_copy(8'd33, 8'd33, 8'd5, 1'b0);

    for (int it = 0; it < 40; it++) begin
      s = 8'($urandom);
      case ($urandom_range(0, 2))
        0: d = 8'($urandom);
        1: d = s + 8'($urandom_range(0, 8));
        default: d = s - 8'($urandom_range(0, 8));
      endcase
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24));
      g = (l >= 8'd2) && ($urandom_range(0, 3) == 0);
      do_copy(s, d, l, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
